// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types and burst-length helper for the memory access scheduler
package mem_sched_pkg;
  typedef enum logic [1:0] {RWC_IDLE = 2'd0, RWC_WRITE = 2'd1, RWC_READ = 2'd2, RWC_BYPASS = 2'd3} rwc_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic {SIDE_WR = 1'b0, SIDE_RD = 1'b1} side_e;
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_burst);
    return len == 0 ? 1 : (len > max_burst ? max_burst : len);
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin (wr/rd) with bypass match; ports: req pair, match, take in; sel pair out
module rr_arbiter2
  import mem_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic rd_req,
  input  logic match,
  input  logic take,
  output logic sel_wr,
  output logic sel_rd
);
  side_e rr_last_q, rr_last_d;
  // rr_last only moves on a genuine contention; single requests and bypass leave it alone
  always_comb begin
    sel_wr = wr_req & (~rd_req | match | (rr_last_q == SIDE_RD));
    sel_rd = rd_req & (~wr_req | match | (rr_last_q == SIDE_WR));
    rr_last_d = (take & wr_req & rd_req & ~match) ? (sel_wr ? SIDE_WR : SIDE_RD) : rr_last_q;
  end
  always_ff @(posedge clk) rr_last_q <= rst ? SIDE_RD : rr_last_d;
endmodule

// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler: burst scheduler sharing a dual-port memory between a write and a read requester; ports: req/addr/len/gnt/beat per side, mem_rwc/wa/ra/start/done, busy, burst_done
module mem_access_scheduler
  import mem_sched_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  parameter int MAX_BURST = 16,
  localparam int LW = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [LW-1:0] wr_len,
  output logic          wr_gnt,
  output logic          wr_beat,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [LW-1:0] rd_len,
  output logic          rd_gnt,
  output logic          rd_beat,
  output logic [1:0]    mem_rwc,
  output logic [AW-1:0] mem_wa,
  output logic [AW-1:0] mem_ra,
  output logic          mem_start,
  input  logic          mem_done,
  output logic          busy,
  output logic          burst_done
);
  state_e state_q, state_d;
  rwc_e op_q, op_d;
  logic [AW-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [LW-1:0] rem_q, rem_d, wr_eff, rd_eff;
  logic first_q, first_d, wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d, done_q, done_d;
  logic sel_wr, sel_rd, match;
  assign wr_eff = LW'(eff_len(32'(wr_len), MAX_BURST));
  assign rd_eff = LW'(eff_len(32'(rd_len), MAX_BURST));
  assign match = (wr_addr == rd_addr) && (wr_eff == rd_eff);
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .match (match),
    .take  (state_q == ST_IDLE),
    .sel_wr(sel_wr),
    .sel_rd(sel_rd)
  );
  // op bit0 marks write participation, bit1 read participation
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    wa_d = wa_q;
    ra_d = ra_q;
    rem_d = rem_q;
    first_d = first_q;
    wr_beat_d = 1'b0;
    rd_beat_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (sel_wr | sel_rd) begin
        op_d = (sel_wr & sel_rd) ? RWC_BYPASS : (sel_wr ? RWC_WRITE : RWC_READ);
        wa_d = sel_wr ? wr_addr : wa_q;
        ra_d = sel_rd ? rd_addr : ra_q;
        rem_d = sel_wr ? wr_eff : rd_eff;
        first_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        first_d = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (mem_done) begin
        wr_beat_d = op_q[0];
        rd_beat_d = op_q[1];
        if (rem_q > LW'(1)) begin
          rem_d = rem_q - LW'(1);
          wa_d = op_q[0] ? wa_q + AW'(1) : wa_q;
          ra_d = op_q[1] ? ra_q + AW'(1) : ra_q;
          state_d = ST_ISSUE;
        end else begin
          done_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q <= RWC_IDLE;
      wa_q <= '0;
      ra_q <= '0;
      rem_q <= '0;
      first_q <= 1'b0;
      wr_beat_q <= 1'b0;
      rd_beat_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      wa_q <= wa_d;
      ra_q <= ra_d;
      rem_q <= rem_d;
      first_q <= first_d;
      wr_beat_q <= wr_beat_d;
      rd_beat_q <= rd_beat_d;
      done_q <= done_d;
    end
  end
  assign mem_start = state_q == ST_ISSUE;
  assign wr_gnt = mem_start & first_q & op_q[0];
  assign rd_gnt = mem_start & first_q & op_q[1];
  assign mem_rwc = state_q == ST_IDLE ? RWC_IDLE : op_q;
  assign mem_wa = wa_q;
  assign mem_ra = ra_q;
  assign busy = state_q != ST_IDLE;
  assign wr_beat = wr_beat_q;
  assign rd_beat = rd_beat_q;
  assign burst_done = done_q;
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb_mem_access_scheduler: directed self-checking bench for mem_access_scheduler
module tb_mem_access_scheduler;
  localparam int AW = 10;
  localparam int LW = 5;
  logic clk = 0, rst = 1;
  logic wr_req = 0, rd_req = 0, mem_done;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [LW-1:0] wr_len = '0, rd_len = '0;
  logic wr_gnt, wr_beat, rd_gnt, rd_beat, mem_start, busy, burst_done;
  logic [1:0] mem_rwc;
  logic [AW-1:0] mem_wa, mem_ra;
  int total = 0, bad = 0;
  int wr_beats = 0, rd_beats = 0, both_beats = 0, dones = 0, wr_gnts = 0, rd_gnts = 0, both_gnts = 0;
  int b_wr, b_rd, b_bb, b_done, b_gw, b_gr, b_bg, b_log;
  logic [1:0] rwc_log[$];
  logic [AW-1:0] wa_log[$], ra_log[$];

  mem_access_scheduler dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt), .wr_beat(wr_beat),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt), .rd_beat(rd_beat),
    .mem_rwc(mem_rwc), .mem_wa(mem_wa), .mem_ra(mem_ra), .mem_start(mem_start),
    .mem_done(mem_done), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  // monitor, requester drop-on-grant, and memory adapter answering 2 cycles after each start
  initial begin
    int dly;
    dly = 0;
    mem_done = 0;
    forever begin
      @(negedge clk);
      if (mem_start) begin
        rwc_log.push_back(mem_rwc);
        wa_log.push_back(mem_wa);
        ra_log.push_back(mem_ra);
      end
      wr_beats += int'(wr_beat);
      rd_beats += int'(rd_beat);
      both_beats += int'(wr_beat & rd_beat);
      dones += int'(burst_done);
      wr_gnts += int'(wr_gnt);
      rd_gnts += int'(rd_gnt);
      both_gnts += int'(wr_gnt & rd_gnt);
      if (wr_gnt) wr_req = 0;
      if (rd_gnt) rd_req = 0;
      mem_done = 0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) mem_done = 1;
      end
      if (mem_start) dly = 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_wr = wr_beats; b_rd = rd_beats; b_bb = both_beats; b_done = dones;
    b_gw = wr_gnts; b_gr = rd_gnts; b_bg = both_gnts; b_log = rwc_log.size();
  endtask

  task automatic wait_bursts(input int target);
    int k;
    k = 0;
    while (dones < target && k < 400) begin
      step();
      k++;
    end
    check("burst_timeout", 32'(dones >= target), 1);
  endtask

  task automatic check_beat(input int idx, input logic [1:0] rwc, input logic [AW-1:0] addr);
    int i;
    i = b_log + idx;
    check($sformatf("rwc[%0d]", i), i < rwc_log.size() ? 32'(rwc_log[i]) : 'x, 32'(rwc));
    if (rwc != 2'd2) check($sformatf("wa[%0d]", i), i < wa_log.size() ? 32'(wa_log[i]) : 'x, 32'(addr));
    if (rwc != 2'd1) check($sformatf("ra[%0d]", i), i < ra_log.size() ? 32'(ra_log[i]) : 'x, 32'(addr));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rwc"}, 32'(mem_rwc), 0);
    check({tag, "_wa"}, 32'(mem_wa), 0);
    check({tag, "_ra"}, 32'(mem_ra), 0);
    check({tag, "_start"}, 32'(mem_start), 0);
    check({tag, "_pulses"}, 32'({wr_gnt, rd_gnt, wr_beat, rd_beat, burst_done}), 0);
  endtask

  initial begin
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 0;
    step();

    // single write burst
    snap();
    wr_addr = 5; wr_len = 3; wr_req = 1;
    step();
    check("wr1_gnt", 32'(wr_gnt), 1);
    check("wr1_start", 32'(mem_start), 1);
    check("wr1_rwc", 32'(mem_rwc), 1);
    check("wr1_busy", 32'(busy), 1);
    wait_bursts(b_done + 1);
    check("wr1_nlog", 32'(rwc_log.size() - b_log), 3);
    check_beat(0, 2'd1, 10'd5);
    check_beat(1, 2'd1, 10'd6);
    check_beat(2, 2'd1, 10'd7);
    check("wr1_beats", 32'(wr_beats - b_wr), 3);
    check("wr1_rbeats", 32'(rd_beats - b_rd), 0);
    check("wr1_gnts", 32'(wr_gnts - b_gw), 1);
    check("wr1_dones", 32'(dones - b_done), 1);
    check("wr1_idle_busy", 32'(busy), 0);
    check("wr1_idle_rwc", 32'(mem_rwc), 0);

    // read burst wrapping the address space
    snap();
    rd_addr = 1022; rd_len = 4; rd_req = 1;
    wait_bursts(b_done + 1);
    check_beat(0, 2'd2, 10'd1022);
    check_beat(1, 2'd2, 10'd1023);
    check_beat(2, 2'd2, 10'd0);
    check_beat(3, 2'd2, 10'd1);
    check("wrap_beats", 32'(rd_beats - b_rd), 4);
    check("wrap_gnts", 32'(rd_gnts - b_gr), 1);
    check("wrap_wa_kept", 32'(mem_wa), 7);

    // contention right after reset state: write wins
    snap();
    wr_addr = 10; wr_len = 2; rd_addr = 20; rd_len = 2; wr_req = 1; rd_req = 1;
    wait_bursts(b_done + 2);
    check("cont1_nlog", 32'(rwc_log.size() - b_log), 4);
    check_beat(0, 2'd1, 10'd10);
    check_beat(1, 2'd1, 10'd11);
    check_beat(2, 2'd2, 10'd20);
    check_beat(3, 2'd2, 10'd21);

    // repeat contention: read wins now
    snap();
    wr_addr = 30; wr_len = 1; rd_addr = 50; rd_len = 1; wr_req = 1; rd_req = 1;
    wait_bursts(b_done + 2);
    check_beat(0, 2'd2, 10'd50);
    check_beat(1, 2'd1, 10'd30);

    // bypass
    snap();
    wr_addr = 40; wr_len = 2; rd_addr = 40; rd_len = 2; wr_req = 1; rd_req = 1;
    wait_bursts(b_done + 1);
    check("byp_nlog", 32'(rwc_log.size() - b_log), 2);
    check_beat(0, 2'd3, 10'd40);
    check_beat(1, 2'd3, 10'd41);
    check("byp_both_gnt", 32'(both_gnts - b_bg), 1);
    check("byp_both_beats", 32'(both_beats - b_bb), 2);
    check("byp_dones", 32'(dones - b_done), 1);

    // length edges
    snap();
    wr_addr = 100; wr_len = 0; wr_req = 1;
    wait_bursts(b_done + 1);
    check("len0_beats", 32'(wr_beats - b_wr), 1);
    check("len0_nlog", 32'(rwc_log.size() - b_log), 1);
    snap();
    rd_addr = 200; rd_len = 31; rd_req = 1;
    wait_bursts(b_done + 1);
    check("len31_beats", 32'(rd_beats - b_rd), 16);
    check("len31_nlog", 32'(rwc_log.size() - b_log), 16);
    check_beat(15, 2'd2, 10'd215);

    // reset during WAIT of beat 2 of 4
    snap();
    wr_addr = 300; wr_len = 4; wr_req = 1;
    for (int k = 0; k < 50 && rwc_log.size() < b_log + 2; k++) step();
    check("rst_reached_beat2", 32'(rwc_log.size() - b_log), 2);
    rst = 1;
    step();
    check_idle_outputs("midrst");
    rst = 0;
    repeat (6) step();
    check("midrst_beats", 32'(wr_beats - b_wr), 1);
    check("midrst_dones", 32'(dones - b_done), 0);
    check("midrst_nlog", 32'(rwc_log.size() - b_log), 2);
    check("midrst_busy", 32'(busy), 0);
    snap();
    rd_addr = 60; rd_len = 1; rd_req = 1;
    wait_bursts(b_done + 1);
    check_beat(0, 2'd2, 10'd60);
    check("post_rst_beats", 32'(rd_beats - b_rd), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
